// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory request/response bus.
// Used by imem_responder and the core's memory controller.
package imem_pkg;

  localparam int BLOCK_WORDS_LOG2 = 3;
  localparam int IMEM_BLOCK_WORDS = 1 << BLOCK_WORDS_LOG2;
  localparam int IMEM_BUS_W       = 32;
  localparam int IMEM_ADDR_W      = 16;

  typedef logic [IMEM_BUS_W-1:0]  bus_word_t;
  typedef logic [IMEM_ADDR_W-1:0] bus_addr_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_WRITE
  } state_t;

endpackage

// File: rtl/imem_storage.sv
// Single-port synchronous RAM backing the instruction memory.
// One-cycle registered read; the read register clears on reset, the array does not.
module imem_storage #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

  // array write; contents survive reset
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // registered read port; cleared so the bus reads zero after reset
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/imem_responder.sv
// Memory-side responder for the instruction-memory block bus.
// Streams BLOCK_WORDS-word read bursts after LATENCY idle cycles and absorbs
// BLOCK_WORDS-word write bursts. Define IMEM_CRITICAL_WORD_FIRST_EN to start
// read bursts at the requested word and wrap within the block.
module imem_responder
  import imem_pkg::*;
#(
  parameter int DATABUS_WIDTH  = IMEM_BUS_W,
  parameter int ADDR_WIDTH     = IMEM_ADDR_W,
  parameter int BLOCK_WORDS    = IMEM_BLOCK_WORDS,
  parameter int MEM_DEPTH_LOG2 = 10,
  parameter int LATENCY        = 2
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic [ADDR_WIDTH-1:0]    address_i,
  input  logic                     makeRequest_i,
  input  logic                     isWrite_i,
  input  logic [DATABUS_WIDTH-1:0] data_i,
  output logic [DATABUS_WIDTH-1:0] data_o,
  output logic                     memEnable_o,
  output logic                     busy_o,
  output logic                     writeDone_o
);

  localparam int OFF_W  = $clog2(BLOCK_WORDS);
  localparam int BASE_W = MEM_DEPTH_LOG2 - OFF_W;
  localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t                    state, state_nxt;
  logic [BASE_W-1:0]         base_q;
  logic [OFF_W-1:0]          cnt;
  logic [LAT_W-1:0]          lat_cnt;
  logic                      drain;
  logic                      last_word;
  logic                      lat_done;
  logic                      ram_we, ram_re;
  logic [OFF_W-1:0]          rd_off;
  logic [OFF_W-1:0]          word_off;
  logic [MEM_DEPTH_LOG2-1:0] ram_addr;
  logic                      unused_addr;

  // Only the low MEM_DEPTH_LOG2 address bits select a word; the rest alias.
  assign unused_addr = ^address_i;

  assign last_word = (cnt == {OFF_W{1'b1}});
  assign lat_done  = (lat_cnt == LAT_W'(LATENCY - 1));
  assign busy_o    = (state != S_IDLE);

`ifdef IMEM_CRITICAL_WORD_FIRST_EN
  logic [OFF_W-1:0] off_q;

  // requested word offset, used as the read burst start
  always_ff @(posedge clock_i) begin
    if (reset_i)                                  off_q <= '0;
    else if (state == S_IDLE && makeRequest_i)    off_q <= address_i[OFF_W-1:0];
  end

  // wraps inside the block, never carries into the base
  assign rd_off = off_q + cnt;
`else
  assign rd_off = cnt;
`endif

  assign word_off = (state == S_WRITE) ? cnt : rd_off;
  assign ram_addr = {base_q, word_off};

  // state register
  always_ff @(posedge clock_i) begin
    if (reset_i) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // next state and store strobes
  always_comb begin
    state_nxt = state;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    case (state)
      S_IDLE: begin
        if (makeRequest_i) begin
          if (isWrite_i)        state_nxt = S_WRITE;
          else if (LATENCY > 0) state_nxt = S_WAIT;
          else                  state_nxt = S_READ;
        end
      end
      S_WAIT: begin
        if (lat_done) state_nxt = S_READ;
      end
      S_READ: begin
        // one extra cycle after the last issue lets the final word land
        if (drain) state_nxt = S_IDLE;
        else       ram_re    = 1'b1;
      end
      S_WRITE: begin
        ram_we = 1'b1;
        if (last_word) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // request latch and burst / latency counters
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      base_q  <= '0;
      cnt     <= '0;
      lat_cnt <= '0;
      drain   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt     <= '0;
          lat_cnt <= '0;
          drain   <= 1'b0;
          if (makeRequest_i) base_q <= address_i[MEM_DEPTH_LOG2-1:OFF_W];
        end
        S_WAIT:  lat_cnt <= lat_cnt + 1'b1;
        S_READ: begin
          if (!drain) begin
            cnt <= cnt + 1'b1;
            if (last_word) drain <= 1'b1;
          end
        end
        S_WRITE: cnt <= cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // valid strobe tracks the registered read data; done pulses after the last write
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      memEnable_o <= 1'b0;
      writeDone_o <= 1'b0;
    end else begin
      memEnable_o <= ram_re;
      writeDone_o <= (state == S_WRITE) && last_word;
    end
  end

  // reset takes priority over a write landing on the same edge
  imem_storage #(
    .WIDTH      (DATABUS_WIDTH),
    .DEPTH_LOG2 (MEM_DEPTH_LOG2)
  ) u_store (
    .clk   (clock_i),
    .rst   (reset_i),
    .we    (ram_we & ~reset_i),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (data_i),
    .rdata (data_o)
  );

endmodule
